// File: rtl/iwdg_window.sv
// iwdg_window: independent watchdog with key/unlock register access, windowed refresh,
// early-warning pulse and a fixed-length reset pulse toward the system reset controller.
module iwdg_window #(
    parameter int          CNT_W      = 12,
    parameter int          RST_LEN    = 4,
    parameter int          EWI_THR    = 64,
    parameter logic [15:0] KEY_START  = 16'hCCCC,
    parameter logic [15:0] KEY_RELOAD = 16'hAAAA,
    parameter logic [15:0] KEY_UNLOCK = 16'h5555
) (
    input  logic             CLOCK,
    input  logic             i_arstn,
    input  logic             i_sel,
    input  logic [1:0]       i_addr,
    input  logic [15:0]      i_wdata,
    input  logic             i_dbg_freeze,
    output logic             o_reset,
    output logic             o_ewi,
    output logic             o_running,
    output logic [CNT_W-1:0] o_cnt
);
    localparam int PW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PULSE} state_t;

    state_t           state, state_n;
    logic             unlock, unlock_n;
    logic [2:0]       pr, pr_n;
    logic [CNT_W-1:0] rlr, rlr_n, winr, winr_n, cnt, cnt_n;
    logic [8:0]       presc, presc_n;
    logic [PW-1:0]    pcnt, pcnt_n;
    logic             ewi_n;
    logic             kr_wr, reg_wr, refresh, tick, viol;

    assign kr_wr   = i_sel && i_addr == 2'd0 && state != PULSE;
    assign reg_wr  = i_sel && i_addr != 2'd0 && unlock && state != PULSE;
    assign refresh = kr_wr && (i_wdata == KEY_RELOAD || i_wdata == KEY_START);
    // terminal prescaler value is 2^(PR+2)-1, i.e. 3..511
    assign tick    = !i_dbg_freeze && presc == (9'h1ff >> (3'd7 - pr));
    assign viol    = winr < rlr && cnt > winr;

    assign o_reset   = state == PULSE;
    assign o_running = state != IDLE;
    assign o_cnt     = cnt;

    always_ff @(posedge CLOCK or negedge i_arstn) begin
        if (!i_arstn) begin
            state  <= IDLE;
            unlock <= 1'b0;
            pr     <= '0;
            rlr    <= '1;
            winr   <= '1;
            presc  <= '0;
            cnt    <= '1;
            pcnt   <= '0;
            o_ewi  <= 1'b0;
        end else begin
            state  <= state_n;
            unlock <= unlock_n;
            pr     <= pr_n;
            rlr    <= rlr_n;
            winr   <= winr_n;
            presc  <= presc_n;
            cnt    <= cnt_n;
            pcnt   <= pcnt_n;
            o_ewi  <= ewi_n;
        end
    end

    always_comb begin
        state_n  = state;
        unlock_n = kr_wr ? i_wdata == KEY_UNLOCK : unlock;
        pr_n     = reg_wr && i_addr == 2'd1 ? i_wdata[2:0] : pr;
        rlr_n    = reg_wr && i_addr == 2'd2 ? i_wdata[CNT_W-1:0] : rlr;
        winr_n   = reg_wr && i_addr == 2'd3 ? i_wdata[CNT_W-1:0] : winr;
        presc_n  = presc;
        cnt_n    = cnt;
        pcnt_n   = pcnt;
        ewi_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (kr_wr && i_wdata == KEY_START) begin
                    state_n = RUN;
                    cnt_n   = rlr;
                    presc_n = '0;
                end
            end
            RUN: begin
                // a refresh takes priority over a coincident tick, even at zero
                if (refresh && !viol) begin
                    cnt_n   = rlr;
                    presc_n = '0;
                end else if (refresh || (tick && cnt == '0)) begin
                    state_n  = PULSE;
                    unlock_n = 1'b0;
                    pcnt_n   = '0;
                end else if (tick) begin
                    cnt_n   = cnt - CNT_W'(1);
                    presc_n = '0;
                    ewi_n   = (cnt - CNT_W'(1)) == CNT_W'(EWI_THR);
                end else if (!i_dbg_freeze) begin
                    presc_n = presc + 9'd1;
                end
            end
            PULSE: begin
                if (pcnt == PW'(RST_LEN - 1)) begin
                    state_n = RUN;
                    cnt_n   = rlr;
                    presc_n = '0;
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_iwdg_window.sv
// tb_iwdg_window: randomized and directed stimulus against a behavioural watchdog model,
// checked through an expected-value queue drained by an independent monitor.
module tb_iwdg_window;
    localparam int          CNT_W      = 12;
    localparam int          RST_LEN    = 4;
    localparam int          EWI_THR    = 64;
    localparam int          KEY_START  = 16'hCCCC;
    localparam int          KEY_RELOAD = 16'hAAAA;
    localparam int          KEY_UNLOCK = 16'h5555;
    localparam int          MAXV       = (1 << CNT_W) - 1;

    logic             CLOCK = 1'b0;
    logic             i_arstn = 1'b0;
    logic             i_sel = 1'b0;
    logic [1:0]       i_addr = '0;
    logic [15:0]      i_wdata = '0;
    logic             i_dbg_freeze = 1'b0;
    logic             o_reset, o_ewi, o_running;
    logic [CNT_W-1:0] o_cnt;

    iwdg_window dut (
        .CLOCK(CLOCK), .i_arstn(i_arstn), .i_sel(i_sel), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_dbg_freeze(i_dbg_freeze), .o_reset(o_reset),
        .o_ewi(o_ewi), .o_running(o_running), .o_cnt(o_cnt)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0, n_bad = 0;
    logic [CNT_W+2:0] exp_q[$];
    int push_no = 0, pop_no = 0;
    int ewi_first, rst_first, n_ewi, n_rst, cnt_min;

    // model state: plain integers describing the watchdog's observable behaviour
    int m_started, m_unlock, m_pr, m_rlr, m_winr, m_div, m_cnt, m_pulse, m_ewi;

    function automatic void check(string nm, longint got, longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    task automatic m_reset();
        m_started = 0; m_unlock = 0; m_pr = 0; m_rlr = MAXV; m_winr = MAXV;
        m_div = 0; m_cnt = MAXV; m_pulse = 0; m_ewi = 0;
    endtask

    task automatic m_step(bit sel, int addr, int data, bit frz);
        bit key, trig;
        int ul0;
        trig = 0;
        m_ewi = 0;
        ul0 = m_unlock;
        if (m_pulse > 0) begin
            m_pulse--;
            if (m_pulse == 0) begin
                m_cnt = m_rlr;
                m_div = 0;
            end
            return;
        end
        key = sel && addr == 0;
        if (key) m_unlock = (data == KEY_UNLOCK);
        if (!m_started) begin
            if (key && data == KEY_START) begin
                m_started = 1; m_cnt = m_rlr; m_div = 0;
            end
        end else if (key && (data == KEY_RELOAD || data == KEY_START)) begin
            if (m_winr < m_rlr && m_cnt > m_winr) trig = 1;
            else begin
                m_cnt = m_rlr; m_div = 0;
            end
        end else if (!frz) begin
            if (m_div == (4 << m_pr) - 1) begin
                m_div = 0;
                if (m_cnt == 0) trig = 1;
                else begin
                    m_cnt--;
                    m_ewi = (m_cnt == EWI_THR);
                end
            end else m_div++;
        end
        if (trig) begin
            m_pulse = RST_LEN; m_unlock = 0;
        end
        if (sel && ul0 != 0) begin
            if (addr == 1) m_pr = data & 7;
            if (addr == 2) m_rlr = data & MAXV;
            if (addr == 3) m_winr = data & MAXV;
        end
    endtask

    task automatic cyc(bit sel, int addr, int data, bit frz);
        @(negedge CLOCK);
        i_sel = sel; i_addr = addr[1:0]; i_wdata = data[15:0]; i_dbg_freeze = frz;
        if (i_arstn) m_step(sel, addr, data, frz);
        exp_q.push_back({m_pulse > 0, m_ewi[0], m_started[0], m_cnt[CNT_W-1:0]});
        push_no++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic wr(int addr, int data);
        cyc(1, addr, data, 0);
    endtask

    task automatic sync();
        idle(1);
        @(posedge CLOCK);
        #2;
    endtask

    task automatic clear_stats();
        ewi_first = -1; rst_first = -1; n_ewi = 0; n_rst = 0; cnt_min = MAXV;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        i_arstn = 1'b0;
        m_reset();
        idle(3);
        i_arstn = 1'b1;
    endtask

    task automatic wait_cnt(int v);
        int b;
        b = 0;
        while (m_cnt != v && b < 5000) begin
            idle(1);
            b++;
        end
        check("wait_cnt_budget", b < 5000, 1);
    endtask

    always @(posedge CLOCK) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [CNT_W+2:0] e;
            e = exp_q.pop_front();
            check("cycle", {o_reset, o_ewi, o_running, o_cnt}, e);
            if (o_ewi) begin
                n_ewi++;
                if (ewi_first < 0) ewi_first = pop_no;
            end
            if (o_reset) begin
                n_rst++;
                if (rst_first < 0) rst_first = pop_no;
            end
            if (o_running && int'(o_cnt) < cnt_min) cnt_min = int'(o_cnt);
            pop_no++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int s, v, b;
        m_reset();
        clear_stats();
        do_reset();
        sync();
        check("reset_running", o_running, 0);
        check("reset_cnt", o_cnt, MAXV);
        check("reset_pulse", o_reset, 0);

        // defaults: expiry after 4*4096 cycles, warning when the counter reaches 64
        wr(0, KEY_START);
        s = push_no - 1;
        idle(4 * (MAXV + 1) + 16);
        sync();
        check("t1_ewi_time", ewi_first - s, 4 * (MAXV - EWI_THR));
        check("t1_rst_time", rst_first - s, 4 * (MAXV + 1));
        check("t1_ewi_count", n_ewi, 1);
        check("t1_rst_len", n_rst, RST_LEN);
        check("t1_running", o_running, 1);

        // regular refresh keeps the counter inside 10..7 and never fires
        do_reset();
        clear_stats();
        wr(0, KEY_UNLOCK); wr(1, 1); wr(2, 10); wr(0, 0); wr(0, KEY_START);
        for (int i = 0; i < 10; i++) begin
            idle(29);
            wr(0, KEY_RELOAD);
        end
        sync();
        check("t2_no_reset", n_rst, 0);
        check("t2_cnt_min", cnt_min, 7);
        wr(2, 3);
        idle(20);
        wr(0, KEY_RELOAD);
        @(posedge CLOCK);
        #2;
        check("t2_locked_rlr", o_cnt, 10);

        // window: early refresh fires, in-window refresh reloads
        do_reset();
        clear_stats();
        wr(0, KEY_UNLOCK); wr(2, 20); wr(3, 8); wr(1, 0); wr(0, KEY_START);
        wait_cnt(15);
        wr(0, KEY_RELOAD);
        idle(RST_LEN + 2);
        sync();
        check("t3_violation", n_rst, RST_LEN);
        wait_cnt(5);
        wr(0, KEY_RELOAD);
        @(posedge CLOCK);
        #2;
        check("t3_valid_cnt", o_cnt, 20);
        check("t3_no_new_rst", n_rst, RST_LEN);

        // refresh on the very tick that would expire the counter
        b = 0;
        while (!(m_cnt == 0 && m_div == 3) && b < 5000) begin
            idle(1);
            b++;
        end
        check("t4_wait_budget", b < 5000, 1);
        wr(0, KEY_RELOAD);
        @(posedge CLOCK);
        #2;
        check("t4_cnt", o_cnt, 20);
        check("t4_reset", o_reset, 0);

        // debug freeze holds everything, release resumes counting
        sync();
        v = int'(o_cnt);
        for (int i = 0; i < 1000; i++) cyc(0, 0, 0, 1);
        sync();
        check("t5_frozen", o_cnt, v);
        check("t5_no_rst", n_rst, RST_LEN);
        idle(20);
        sync();
        check("t5_resumed", int'(o_cnt) < v, 1);

        // asynchronous reset in the second cycle of a pulse
        b = 0;
        while (m_pulse != RST_LEN - 1 && b < 5000) begin
            idle(1);
            b++;
        end
        check("t6_wait_budget", b < 5000, 1);
        @(posedge CLOCK);
        #3;
        check("t6_pulse_before", o_reset, 1);
        i_arstn = 1'b0;
        #1;
        check("t6_async_reset", o_reset, 0);
        check("t6_async_running", o_running, 0);
        m_reset();
        idle(2);
        i_arstn = 1'b1;
        wr(0, KEY_RELOAD);
        idle(5);
        sync();
        check("t6_reload_ignored", o_running, 0);
        wr(0, KEY_START);
        @(posedge CLOCK);
        #2;
        check("t6_restart", o_running, 1);

        // randomized traffic
        do_reset();
        wr(0, KEY_UNLOCK);
        wr(1, $urandom_range(0, 1));
        v = $urandom_range(20, 80);
        wr(2, v);
        wr(3, $urandom_range(5, v + 10));
        wr(0, KEY_START);
        for (int i = 0; i < 3000; i++) begin
            int r, d;
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 4))
                0: d = KEY_RELOAD;
                1: d = KEY_START;
                2: d = KEY_UNLOCK;
                default: d = $urandom_range(0, 255);
            endcase
            cyc(r < 10, (r < 6) ? 0 : $urandom_range(1, 3), d, $urandom_range(0, 9) == 0);
        end
        sync();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
